input_debouncer: RTL

- Conditions a raw, asynchronous 1-bit input (switch or button) before it drives the single-bit logic stages, including the inverter.
- Synchronises the input into the clock domain and filters glitches shorter than a programmable number of cycles.
- Outputs a clean registered level `y`, plus one-cycle `rise`/`fall` pulses for downstream logic.

---
 rtl/input_debouncer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser feeding a glitch-filter FSM with rise/fall pulses.
// Optional macro DEBOUNCE_INVERT_EN presents the complemented level (reset y=1, pulses swapped).
module input_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_WAIT_HIGH,
      ST_HIGH,
      ST_WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
   localparam bit               LP_DIRECT = (STABLE_CYCLES <= 1);
`ifdef DEBOUNCE_INVERT_EN
   localparam logic LP_INV = 1'b1;
`else
   localparam logic LP_INV = 1'b0;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_y;
   logic             r_rise;
   logic             r_fall;
   logic             w_level_nxt;
   logic             w_enter_high;
   logic             w_enter_low;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= a;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOW;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_LOW: begin
            if (r_s2) begin
               if (LP_DIRECT) begin
                  w_state_nxt = ST_HIGH;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_WAIT_HIGH;
                  w_cnt_nxt   = LP_ONE;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + LP_ONE;
            end
         end
         ST_HIGH: begin
            if (!r_s2) begin
               if (LP_DIRECT) begin
                  w_state_nxt = ST_LOW;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_WAIT_LOW;
                  w_cnt_nxt   = LP_ONE;
               end
            end
         end
         ST_WAIT_LOW: begin
            if (r_s2) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = ST_LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + LP_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // An aborted WAIT_LOW returning to HIGH is not an edge, so only qualified entries count.
   always_comb begin
      w_enter_high = (w_state_nxt == ST_HIGH) &&
                     ((r_state == ST_LOW) || (r_state == ST_WAIT_HIGH));
      w_enter_low  = (w_state_nxt == ST_LOW) &&
                     ((r_state == ST_HIGH) || (r_state == ST_WAIT_LOW));
      w_level_nxt  = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_WAIT_LOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y    <= LP_INV;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_y    <= w_level_nxt ^ LP_INV;
         r_rise <= LP_INV ? w_enter_low  : w_enter_high;
         r_fall <= LP_INV ? w_enter_high : w_enter_low;
      end
   end

   assign y    = r_y;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);

endmodule
